minterm_extractor: RTL and testbench



---
 rtl/minterm_pkg.sv | 20 ++
 rtl/minterm_extractor_next_term_finder.sv | 30 +++
 rtl/minterm_extractor.sv | 137 +++++++++++++
 tb/tb_minterm_extractor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/minterm_pkg.sv
// Shared types and sizing helpers for the truth-table extractor.
// No logic of its own; pure declarations.
// Imported by minterm_extractor and next_term_finder.
package minterm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int N_DEFAULT = 3;

    // Number of truth-table rows (and mask bits) for an n-input function.
    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/minterm_extractor_next_term_finder.sv
// Priority search: lowest index >= start_pos whose mask bit differs from mode.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the result.
module next_term_finder
    import minterm_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [tt_width(N)-1:0] mask,
    input  logic                   mode,
    input  logic [N:0]             start_pos,
    output logic                   found,
    output logic [N-1:0]           idx
);

    localparam int M = tt_width(N);

    // Walk downward so the last hit written is the lowest qualifying index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (((N + 1)'(i) >= start_pos) && (mask[i] ^ mode)) begin
                found = 1'b1;
                idx   = N'(i);
            end
        end
    end

endmodule

// File: rtl/minterm_extractor.sv
// Sweeps an N-input function through all 2^N inputs, captures its truth table, then streams minterm/maxterm indices.
// Latency: 2^N sweep cycles, then one cycle per scanned index (linear) or per emitted term (MINTERM_EXTRACTOR_FASTSCAN_EN), then one DONE cycle.
// Backpressure: a presented term holds term_valid/term_idx stable until term_ready; each stalled cycle adds one cycle.
module minterm_extractor
    import minterm_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mode,
    output logic [N-1:0]           x_out,
    input  logic                   f_in,
    output logic                   busy,
    output logic                   term_valid,
    output logic [N-1:0]           term_idx,
    input  logic                   term_ready,
    output logic                   done,
    output logic [N:0]             count,
    output logic [tt_width(N)-1:0] mask
);

    localparam int M = tt_width(N);
    localparam logic [N-1:0] LAST_IDX = '1;

    state_t         state;
    logic           mode_q;
    logic [N-1:0]   idx;
    logic           match;

    // Outputs decode registered state only, so term_ready and f_in never reach them.
    assign match      = mask[idx] ^ mode_q;
    assign term_valid = (state == ST_EMIT) && match;
    assign term_idx   = idx;
    assign done       = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);

`ifdef MINTERM_EXTRACTOR_FASTSCAN_EN
    logic [M-1:0] search_mask;
    logic [N:0]   search_from;
    logic         nxt_found;
    logic [N-1:0] nxt_idx;

    // During the last sweep cycle the final mask bit is still on f_in, so fold it in for the first search.
    always_comb begin
        search_mask = mask;
        if (state == ST_SWEEP) begin
            search_mask[x_out] = f_in;
        end
    end

    // Search strictly past the current term while emitting; from zero when entering EMIT.
    assign search_from = (state == ST_EMIT) ? ({1'b0, idx} + 1'b1) : '0;

    next_term_finder #(.N(N)) u_finder (
        .mask      (search_mask),
        .mode      (mode_q),
        .start_pos (search_from),
        .found     (nxt_found),
        .idx       (nxt_idx)
    );
`endif

    // Main control: sweep, capture, then scan/emit terms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            x_out  <= '0;
            mode_q <= 1'b0;
            mask   <= '0;
            count  <= '0;
            idx    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_SWEEP;
                        x_out  <= '0;
                        mode_q <= mode;
                        mask   <= '0;
                        count  <= '0;
                    end
                end
                ST_SWEEP: begin
                    mask[x_out] <= f_in;
                    if (x_out == LAST_IDX) begin
`ifdef MINTERM_EXTRACTOR_FASTSCAN_EN
                        if (nxt_found) begin
                            state <= ST_EMIT;
                            idx   <= nxt_idx;
                        end else begin
                            state <= ST_DONE;
                        end
`else
                        state <= ST_EMIT;
                        idx   <= '0;
`endif
                    end else begin
                        x_out <= x_out + 1'b1;
                    end
                end
                ST_EMIT: begin
`ifdef MINTERM_EXTRACTOR_FASTSCAN_EN
                    // idx always points at a matching term here.
                    if (term_ready) begin
                        count <= count + 1'b1;
                        if (nxt_found) begin
                            idx <= nxt_idx;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
`else
                    if (!match || term_ready) begin
                        if (match) begin
                            count <= count + 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_extractor.sv
// Directed bench for minterm_extractor (N=3) with a live function model on x_out.
// Latency checked via a cycle counter aligned to the start-sampling edge.
// Backpressure exercised by stalling term_ready at the first term.
module tb_minterm_extractor;

    localparam int N = 3;

`ifdef MINTERM_EXTRACTOR_FASTSCAN_EN
    localparam int DONE_4TERMS = 13;
    localparam int DONE_0TERMS = 9;
`else
    localparam int DONE_4TERMS = 17;
    localparam int DONE_0TERMS = 17;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [N-1:0] x_out;
    logic         f_in;
    logic         busy;
    logic         term_valid;
    logic [N-1:0] term_idx;
    logic         term_ready = 1'b1;
    logic         done;
    logic [N:0]   count;
    logic [7:0]   mask;

    int f_sel = 0;
    logic fx, fy, fw, f1, f2;

    int checks = 0;
    int errors = 0;
    int cyc, done_cyc, hold0, valid_cnt;
    bit aborted;
    int acc_q[$];

    minterm_extractor #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .x_out      (x_out),
        .f_in       (f_in),
        .busy       (busy),
        .term_valid (term_valid),
        .term_idx   (term_idx),
        .term_ready (term_ready),
        .done       (done),
        .count      (count),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    // Function under test: x is the leftmost variable.
    assign fx   = x_out[2];
    assign fy   = x_out[1];
    assign fw   = x_out[0];
    assign f1   = (~fx & ~fw) | (fx & ~fy);
    assign f2   = (fx | ~fw) & (~fx | ~fy);
    assign f_in = (f_sel == 1) ? f1 : (f_sel == 2) ? f2 : 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_valid"}, term_valid, 0);
        check({tag, "_idx"},   term_idx,   0);
        check({tag, "_done"},  done,       0);
        check({tag, "_busy"},  busy,       0);
        check({tag, "_count"}, count,      0);
        check({tag, "_mask"},  mask,       0);
        check({tag, "_xout"},  x_out,      0);
    endtask

    task automatic check_terms(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        check({tag, "_nterms"}, acc_q.size(), 4);
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            check($sformatf("%s_term%0d", tag, i), acc_q[i], e[i]);
        end
    endtask

    // One extraction; stall = ready-low cycles at the first term, poke = stray starts, abort_after = reset after that many accepts.
    task automatic run(input int fsel, input bit m, input int stall, input bit poke, input int abort_after);
        int stall_left;
        bit abort_pend;
        stall_left = stall;
        abort_pend = 0;
        aborted    = 0;
        acc_q.delete();
        hold0      = 0;
        valid_cnt  = 0;
        done_cyc   = -1;
        f_sel      = fsel;
        @(negedge clk);
        start      = 1'b1;
        mode       = m;
        term_ready = 1'b1;
        @(posedge clk);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = poke && (cyc == 3);
            mode  = ~m;
            if (abort_pend) begin
                rst_n = 1'b0;
                #1;
                aborted = 1;
                break;
            end
            if (cyc == 1) check("sweep_x_first", x_out, 0);
            if (cyc == 8) begin
                check("sweep_x_last", x_out, 7);
                check("sweep_busy", busy, 1);
            end
            if (term_valid && stall_left > 0) begin
                term_ready = 1'b0;
                stall_left--;
            end else begin
                term_ready = 1'b1;
            end
            if (term_valid) begin
                valid_cnt++;
                if (term_idx == 0) hold0++;
            end
            if (term_valid && term_ready) begin
                acc_q.push_back(int'(term_idx));
                if (abort_after > 0 && acc_q.size() == abort_after) abort_pend = 1;
            end
            if (done) begin
                done_cyc = cyc;
                if (poke) start = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            if (done_cyc < 0) check("done_timeout", 0, 1);
            @(negedge clk);
            start = 1'b0;
            mode  = 1'b0;
            check("done_one_cycle", done, 0);
            check("idle_after_done", busy, 0);
        end
        term_ready = 1'b1;
    endtask

    initial begin
        #12;
        check_reset_outs("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        // Minterms of f1.
        run(1, 1'b0, 0, 1'b0, 0);
        check("t1_mask", mask, 8'h35);
        check("t1_count", count, 4);
        check("t1_done_cyc", done_cyc, DONE_4TERMS);
        check("t1_valid_cnt", valid_cnt, 4);
        check("t1_xout_hold", x_out, 7);
        check_terms("t1", 0, 2, 4, 5);

        // Maxterms of f2.
        run(2, 1'b1, 0, 1'b0, 0);
        check("t2_mask", mask, 8'h35);
        check("t2_count", count, 4);
        check("t2_done_cyc", done_cyc, DONE_4TERMS);
        check_terms("t2", 1, 3, 6, 7);

        // Constant zero, no terms.
        run(0, 1'b0, 0, 1'b0, 0);
        check("t3_mask", mask, 0);
        check("t3_count", count, 0);
        check("t3_valid_cnt", valid_cnt, 0);
        check("t3_done_cyc", done_cyc, DONE_0TERMS);

        // Backpressure on the first term.
        run(1, 1'b0, 3, 1'b0, 0);
        check("t4_hold0", hold0, 4);
        check("t4_done_cyc", done_cyc, DONE_4TERMS + 3);
        check("t4_count", count, 4);
        check_terms("t4", 0, 2, 4, 5);

        // Reset mid-EMIT after two accepted terms.
        run(1, 1'b0, 0, 1'b0, 2);
        check("t5_aborted", aborted, 1);
        check("t5_accepted", acc_q.size(), 2);
        check_reset_outs("t5_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_done", done, 0);
        end
        rst_n = 1'b1;
        run(1, 1'b0, 0, 1'b0, 0);
        check("t5_count", count, 4);
        check_terms("t5", 0, 2, 4, 5);

        // Stray start pulses during SWEEP and DONE.
        run(1, 1'b0, 0, 1'b1, 0);
        check("t6_done_cyc", done_cyc, DONE_4TERMS);
        check("t6_count", count, 4);
        check_terms("t6", 0, 2, 4, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
